// File: rtl/shared_inv_sbox_pipe.sv
// shared_inv_sbox_pipe
//   Two-share masked uBlock inverse S-box layer over a 32-bit word
//   (8 nibbles), decryption counterpart of the key-schedule shared S-box.
//   Each nibble is computed as Sinv = G o F in two quadratic stages, with a
//   register bank after F (stage 1) and after G (stage 2, the outputs).
//   Valid/ready flow control on both sides. Stage 1 may accept while it
//   hands over to stage 2. A pop with no refill zeroes the output shares
//   when CLEAR_ON_POP is set.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     input handshake
//   in_share0 / in_share1   input shares, nibble i at [4i+3:4i]
//   out_valid / out_ready   output handshake
//   out_share0 / out_share1 result shares
//   busy                    either pipeline stage holds a word
module shared_inv_sbox_pipe #(
    parameter bit CLEAR_ON_POP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_share0,
    input  logic [31:0] in_share1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_share0,
    output logic [31:0] out_share1,
    output logic        busy
);

    // Shared product term: own_i * (own_j ^ oth_j). It is kept as two
    // separate AND terms so that share 0 and share 1 of bit j are never
    // XORed together before a register.
    function automatic logic dmul(input logic own_i, input logic own_j,
                                  input logic oth_j);
        return (own_i & own_j) ^ (own_i & oth_j);
    endfunction

    // F: passes the nibble through, refreshed with the guard nibble, and
    // appends the product x0*x3. Sinv has only two cubic monomials,
    // x0x1x3 and x0x2x3, and both contain x0x3. Precomputing that product
    // keeps G quadratic.
    function automatic logic [4:0] f_share(input logic [3:0] own,
                                           input logic [3:0] oth,
                                           input logic [3:0] g);
        logic p;
        p = dmul(own[0], own[3], oth[3]) ^ g[0];
        return {p, own ^ g};
    endfunction

    // G: quadratic in (x3..x0, p). The constant terms go into share 0
    // only (cst=1).
    function automatic logic [3:0] g_share(input logic [4:0] own,
                                           input logic [4:0] oth,
                                           input logic [3:0] h,
                                           input logic       cst);
        logic [3:0] y;
        y[0] = dmul(own[0], own[1], oth[1]) ^ own[2] ^ own[3] ^ own[4]
             ^ dmul(own[4], own[1], oth[1]) ^ dmul(own[2], own[3], oth[3]);
        y[1] = own[0] ^ own[1] ^ own[3] ^ own[4];
        y[2] = cst ^ own[0] ^ dmul(own[0], own[1], oth[1]) ^ own[2];
        y[3] = cst ^ own[2] ^ own[3]
             ^ dmul(own[0], own[2], oth[2]) ^ dmul(own[1], own[2], oth[2])
             ^ dmul(own[2], own[3], oth[3]) ^ dmul(own[4], own[2], oth[2]);
        return y ^ h;
    endfunction

    logic            v1_q, v1_d;
    logic [7:0][4:0] s1_sh0_q, s1_sh0_d;
    logic [7:0][4:0] s1_sh1_q, s1_sh1_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_sh0_q, out_sh0_d;
    logic [31:0]     out_sh1_q, out_sh1_d;

    logic [7:0][3:0] in0_n, in1_n;
    logic [7:0][4:0] f_sh0, f_sh1;
    logic [7:0][3:0] g_sh0, g_sh1;
    logic            adv2, accept, move2, pop;

    always_comb begin
        logic [2:0] ni;
        logic [2:0] gi;
        ni    = '0;
        gi    = '0;
        in0_n = in_share0;
        in1_n = in_share1;
        f_sh0 = '0;
        f_sh1 = '0;
        g_sh0 = '0;
        g_sh1 = '0;

        // The guard for nibble i is share-0 nibble (i+7) mod 8 of the same
        // stage input. The 3-bit index wraps nibble 0 onto nibble 7.
        for (int unsigned i = 0; i < 8; i++) begin
            ni = 3'(i);
            gi = 3'(i + 7);
            f_sh0[ni] = f_share(in0_n[ni], in1_n[ni], in0_n[gi]);
            f_sh1[ni] = f_share(in1_n[ni], in0_n[ni], in0_n[gi]);
            g_sh0[ni] = g_share(s1_sh0_q[ni], s1_sh1_q[ni], s1_sh0_q[gi][3:0], 1'b1);
            g_sh1[ni] = g_share(s1_sh1_q[ni], s1_sh0_q[ni], s1_sh0_q[gi][3:0], 1'b0);
        end

        adv2     = !out_valid_q || out_ready;
        in_ready = !v1_q || adv2;
        accept   = in_valid && in_ready;
        move2    = v1_q && adv2;
        pop      = out_valid_q && out_ready;

        v1_d        = v1_q;
        s1_sh0_d    = s1_sh0_q;
        s1_sh1_d    = s1_sh1_q;
        out_valid_d = out_valid_q;
        out_sh0_d   = out_sh0_q;
        out_sh1_d   = out_sh1_q;

        if (accept) begin
            v1_d     = 1'b1;
            s1_sh0_d = f_sh0;
            s1_sh1_d = f_sh1;
        end else if (move2) begin
            v1_d = 1'b0;
        end

        if (move2) begin
            out_valid_d = 1'b1;
            out_sh0_d   = g_sh0;
            out_sh1_d   = g_sh1;
        end else if (pop) begin
            out_valid_d = 1'b0;
            if (CLEAR_ON_POP) begin
                out_sh0_d = '0;
                out_sh1_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            s1_sh0_q    <= '0;
            s1_sh1_q    <= '0;
            out_valid_q <= 1'b0;
            out_sh0_q   <= '0;
            out_sh1_q   <= '0;
        end else begin
            v1_q        <= v1_d;
            s1_sh0_q    <= s1_sh0_d;
            s1_sh1_q    <= s1_sh1_d;
            out_valid_q <= out_valid_d;
            out_sh0_q   <= out_sh0_d;
            out_sh1_q   <= out_sh1_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_share0 = out_sh0_q;
    assign out_share1 = out_sh1_q;
    assign busy       = v1_q || out_valid_q;

endmodule

// File: tb/tb_shared_inv_sbox_pipe.sv
// tb_shared_inv_sbox_pipe
//   Testbench for shared_inv_sbox_pipe. Expected results are queued when
//   a word is accepted and compared against the recombined output shares
//   when the output handshake occurs.
module tb_shared_inv_sbox_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_share0, in_share1;
    logic        out_valid, out_ready;
    logic [31:0] out_share0, out_share1;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int n_out  = 0;
    bit lat_chk = 1'b0;
    logic [31:0] cur_exp;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t exp_q[$];
    sb_t mon_e;

    typedef struct {
        logic [31:0] plain;
        logic [31:0] sh0;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    localparam logic [3:0] SINV [16] = '{4'hC, 4'hA, 4'hE, 4'hD, 4'h1, 4'hF, 4'hB, 4'h0,
                                         4'h7, 4'h2, 4'h5, 4'h4, 4'h3, 4'h6, 4'h9, 4'h8};

    shared_inv_sbox_pipe #(.CLEAR_ON_POP(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_share0 (in_share0),
        .in_share1 (in_share1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_share0(out_share0),
        .out_share1(out_share1),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sinv_word(input logic [31:0] x);
        logic [7:0][3:0] xn;
        logic [7:0][3:0] rn;
        xn = x;
        for (int i = 0; i < 8; i++) rn[i] = SINV[xn[i]];
        return rn;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL spurious_output: got %h, want no output (t=%0t)",
                             out_share0 ^ out_share1, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", out_share0 ^ out_share1, mon_e.data);
                    if (lat_chk) chk("latency", cyc - mon_e.cyc, 2);
                end
            end
            if (in_valid && in_ready) exp_q.push_back('{cur_exp, cyc});
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [31:0] plain, input logic [31:0] sh0,
                        input logic [31:0] exp, input bit want_ready);
        bit acc;
        acc       = 1'b0;
        in_share0 = sh0;
        in_share1 = sh0 ^ plain;
        cur_exp   = exp;
        in_valid  = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (want_ready) chk("in_ready_stream", in_ready, 1);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            $display("FAIL send_timeout: in_ready stayed 0, want 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0][3:0] w;
        logic [31:0] a, b, c, r, snap0, snap1;
        int n0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_share0 = '0;
        in_share1 = '0;
        cur_exp   = '0;

        vecs[0] = '{32'h01234567, 32'hA5A5A5A5, 32'hCAED1FB0};
        vecs[1] = '{32'h89ABCDEF, 32'h3C3C3C3C, 32'h72543698};
        vecs[2] = '{32'hFEDCBA98, 32'h12345678, 32'h89634527};
        vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 32'hCCCCCCCC};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 32'h88888888};
        vecs[5] = '{32'h77777777, 32'hDEADBEEF, 32'h00000000};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_share0", out_share0, 0);
        chk("rst_out_share1", out_share1, 0);
        rst_n = 1'b1;
        #1 chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Fixed vectors, streamed back to back
        foreach (vecs[i]) send(vecs[i].plain, vecs[i].sh0, vecs[i].exp, 1'b1);
        in_valid = 1'b0;
        drain();

        // Every value in every nibble, random splits, 16 words streamed, 2-cycle latency
        lat_chk = 1'b1;
        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i < 8; i++) w[i] = 4'(v + i);
            send(w, $urandom, sinv_word(w), 1'b1);
        end
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        // Backpressure: out_ready low for 5 cycles, 3 words offered
        n0 = n_out;
        a = $urandom; b = $urandom; c = $urandom;
        out_ready = 1'b0;
        send(a, $urandom, sinv_word(a), 1'b1);
        send(b, $urandom, sinv_word(b), 1'b1);
        r = $urandom;
        in_share0 = r;
        in_share1 = r ^ c;
        cur_exp   = sinv_word(c);
        in_valid  = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 1);
        chk("bp_out_valid", out_valid, 1);
        snap0 = out_share0;
        snap1 = out_share1;
        chk("bp_head", snap0 ^ snap1, sinv_word(a));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            in_share0 = $urandom;
            in_share1 = $urandom;
            cur_exp   = sinv_word(in_share0 ^ in_share1);
            @(negedge clk);
            chk("bp_in_ready_hold", in_ready, 0);
            chk("bp_share0_stable", out_share0, snap0);
            chk("bp_share1_stable", out_share1, snap1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(c, r, sinv_word(c), 1'b0);
        in_valid = 1'b0;
        drain();
        chk("bp_word_count", n_out - n0, 3);

        // Pop with no refill clears the output shares
        a = $urandom;
        send(a, $urandom, sinv_word(a), 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("pop_valid_seen", out_valid, 1);
        @(negedge clk);
        chk("pop_out_valid", out_valid, 0);
        chk("pop_share0", out_share0, 0);
        chk("pop_share1", out_share1, 0);
        chk("pop_busy", busy, 0);
        @(posedge clk);
        #1;

        // Reset while both stages are full
        a = $urandom; b = $urandom;
        out_ready = 1'b0;
        send(a, $urandom, sinv_word(a), 1'b1);
        send(b, $urandom, sinv_word(b), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_busy", busy, 1);
        chk("full_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_share0", out_share0, 0);
        chk("midrst_share1", out_share1, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1 chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(32'h01234567, 32'h5A5A5A5A, 32'hCAED1FB0, 1'b1);
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shared_inv_sbox_pipe.md
SHARED_INV_SBOX_PIPE -- requirements
Module: shared_inv_sbox_pipe

Interface
REQ-001 Parameter: CLEAR_ON_POP, default 1, when 1 the output share registers SHALL be zeroed on an output handshake that does not reload them.
REQ-002 clk  input  1  single clock; all registers SHALL be rising-edge triggered.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 in_valid  input  1  a 2-share input word is presented.
REQ-005 in_ready  output  1  the block accepts the input word this cycle.
REQ-006 in_share0  input  32  share 0 of the input word; nibble i at bits [4i+3:4i].
REQ-007 in_share1  input  32  share 1 of the input word; same nibble layout.
REQ-008 out_valid  output  1  the output shares hold a result.
REQ-009 out_ready  input  1  the consumer takes the result this cycle.
REQ-010 out_share0  output  32  share 0 of the result.
REQ-011 out_share1  output  32  share 1 of the result.
REQ-012 busy  output  1  high while either pipeline stage holds valid data.

Function
REQ-013 The block SHALL be the decryption-direction counterpart of the key-schedule shared S-box layer, applying the uBlock inverse S-box to each of the 8 nibbles in 2-share threshold form.
REQ-014 The inverse S-box table for x=0..F SHALL be C,A,E,D,1,F,B,0,7,2,5,4,3,6,9,8.
REQ-015 Correctness: (out_share0 XOR out_share1) nibble i SHALL equal Sinv((in_share0 XOR in_share1) nibble i) for every accepted word.
REQ-016 Each nibble SHALL be computed as two decomposed quadratic stages F then G (Sinv = G o F), with a register bank after F (stage 1) and after G (stage 2, the output registers).
REQ-017 No combinational path SHALL recombine share 0 and share 1 of the same nibble before a register boundary.
REQ-018 Guard shares for nibble i SHALL be share-0 nibble (i+7) mod 8 of the same stage input, which wraps nibble 0 to nibble 7.
REQ-019 The stage-1 register SHALL capture when in_valid and in_ready are both high; v1 SHALL be its valid flag.
REQ-020 The stage-2 register SHALL capture from stage 1 when v1 and adv2 are both high, where adv2 = !out_valid || out_ready.
REQ-021 in_ready SHALL equal !v1 || adv2 as a combinational output.
REQ-022 out_valid SHALL be the stage-2 valid flag and SHALL drop only after an out_valid && out_ready handshake with no refill.
REQ-023 Latency: with out_ready held high, out_valid SHALL assert exactly 2 cycles after the accept edge.
REQ-024 Throughput SHALL be one word per cycle when there is no backpressure.
REQ-025 Backpressure: while out_valid=1 and out_ready=0, the output shares SHALL hold stable, stage 1 SHALL hold, and in_ready SHALL equal !v1.
REQ-026 Simultaneous pop and refill SHALL load the new stage-2 data in the same edge, with no bubble.
REQ-027 Simultaneous accept into stage 1 and transfer out of stage 1 SHALL be legal, and data order SHALL be preserved.
REQ-028 When CLEAR_ON_POP=1 and a pop occurs with no refill, out_share0 and out_share1 SHALL become 0.
REQ-029 Input shares SHALL be sampled only on accept; changes while in_ready=0 SHALL have no effect.
REQ-030 busy SHALL equal v1 || out_valid.

Reset
REQ-031 rst_n low SHALL immediately (asynchronously) clear v1, out_valid and every share register to 0, with out_share0/out_share1 = 0 and busy = 0.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight words; no partial result SHALL appear after release.
REQ-033 After rst_n rises, in_ready SHALL be 1 at the first clock edge.

Verification
REQ-034 Exhaustive nibble test: all 16 values in every nibble, with random share splits and out_ready=1 -> recombined output matches the REQ-014 table, and each result appears 2 cycles after accept.
REQ-035 Word test: unmasked input 0x01234567 split with share0=0xA5A5A5A5 -> recombined output 0xCAED1FB0.
REQ-036 Streaming: 10 back-to-back words with out_ready=1 -> 10 results on consecutive cycles, in order, with in_ready held at 1.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles with 3 words offered -> 2 words are held, in_ready=0 with both stages full, outputs are stable, and no word is lost or duplicated after release.
REQ-038 Pop without refill with CLEAR_ON_POP=1 -> out_valid=0 and both output shares 0x00000000 on the next cycle.
REQ-039 Assert rst_n low while both stages are full -> outputs, out_valid and busy go to 0 immediately; after release the next accepted word yields the correct result.
